// File: rtl/bp_be_fp_pipe_ctrl.sv
// FP issue/writeback controller: tracks the fixed-latency pipe and one iterative
// div/sqrt unit, shares the single writeback port, and keeps a per-register scoreboard.
module bp_be_fp_pipe_ctrl #(
  parameter int pipe_latency_p   = 4,
  parameter int reg_addr_width_p = 5
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           dispatch_v_i,
  input  logic                           dispatch_iter_i,
  input  logic [reg_addr_width_p-1:0]    dispatch_rd_i,
  output logic                           dispatch_ready_o,
  input  logic                           flush_i,
  output logic                           pipe_launch_o,
  output logic                           iter_start_o,
  output logic                           iter_kill_o,
  input  logic                           iter_done_i,
  output logic                           wb_v_o,
  output logic                           wb_iter_o,
  output logic [reg_addr_width_p-1:0]    wb_rd_o,
  output logic [2**reg_addr_width_p-1:0] rd_busy_o,
  output logic                           busy_o
);

  localparam int rf_els_lp = 2**reg_addr_width_p;

  localparam logic [1:0] state_idle_c = 2'd0;
  localparam logic [1:0] state_iter_c = 2'd1;
  localparam logic [1:0] state_done_c = 2'd2;

  logic [pipe_latency_p-1:0]   pipe_v_q, pipe_v_d;
  logic [reg_addr_width_p-1:0] pipe_rd_q [pipe_latency_p];
  logic [reg_addr_width_p-1:0] pipe_rd_d [pipe_latency_p];
  logic [1:0]                  state_q, state_d;
  logic [reg_addr_width_p-1:0] iter_rd_q, iter_rd_d;
  logic [rf_els_lp-1:0]        rd_busy_s;
  logic                        final_v_s;
  logic                        accept_s;

  // Scoreboard: every valid pipe entry plus the iterative op while it is outstanding.
  always_comb begin
    rd_busy_s = '0;
    for (int i = 0; i < pipe_latency_p; i++) begin
      rd_busy_s[pipe_rd_q[i]] = rd_busy_s[pipe_rd_q[i]] | pipe_v_q[i];
    end
    rd_busy_s[iter_rd_q] = rd_busy_s[iter_rd_q] | (state_q != state_idle_c);
  end

  always_comb begin
    final_v_s        = pipe_v_q[pipe_latency_p-1];
    dispatch_ready_o = !reset_i && !flush_i && !rd_busy_s[dispatch_rd_i]
                       && (!dispatch_iter_i || (state_q == state_idle_c));
    accept_s         = dispatch_v_i && dispatch_ready_o;
    pipe_launch_o    = accept_s && !dispatch_iter_i;
    iter_start_o     = accept_s && dispatch_iter_i;
    iter_kill_o      = !reset_i && flush_i && (state_q == state_iter_c);
    busy_o           = !reset_i && ((|pipe_v_q) || (state_q != state_idle_c));
    rd_busy_o        = reset_i ? '0 : rd_busy_s;
    // The pipe owns the writeback port whenever its final entry is valid.
    if (reset_i || flush_i) begin
      wb_v_o    = 1'b0;
      wb_iter_o = 1'b0;
      wb_rd_o   = '0;
    end else if (final_v_s) begin
      wb_v_o    = 1'b1;
      wb_iter_o = 1'b0;
      wb_rd_o   = pipe_rd_q[pipe_latency_p-1];
    end else if (state_q == state_done_c) begin
      wb_v_o    = 1'b1;
      wb_iter_o = 1'b1;
      wb_rd_o   = iter_rd_q;
    end else begin
      wb_v_o    = 1'b0;
      wb_iter_o = 1'b0;
      wb_rd_o   = '0;
    end
  end

  always_comb begin
    pipe_v_d[0]  = pipe_launch_o;
    pipe_rd_d[0] = dispatch_rd_i;
    for (int i = 1; i < pipe_latency_p; i++) begin
      pipe_v_d[i]  = pipe_v_q[i-1] && !flush_i;
      pipe_rd_d[i] = pipe_rd_q[i-1];
    end
    iter_rd_d = iter_start_o ? dispatch_rd_i : iter_rd_q;
    state_d   = state_q;
    if (flush_i) begin
      state_d = state_idle_c;
    end else begin
      case (state_q)
        state_idle_c: state_d = iter_start_o ? state_iter_c : state_idle_c;
        state_iter_c: state_d = iter_done_i ? state_done_c : state_iter_c;
        state_done_c: state_d = final_v_s ? state_done_c : state_idle_c;
        default:      state_d = state_idle_c;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pipe_v_q  <= '0;
      state_q   <= state_idle_c;
      iter_rd_q <= '0;
      for (int i = 0; i < pipe_latency_p; i++) begin
        pipe_rd_q[i] <= '0;
      end
    end else begin
      pipe_v_q  <= pipe_v_d;
      state_q   <= state_d;
      iter_rd_q <= iter_rd_d;
      pipe_rd_q <= pipe_rd_d;
    end
  end

endmodule

// File: doc/bp_be_fp_pipe_ctrl.md
BP_BE_FP_PIPE_CTRL -- requirements
Module: bp_be_fp_pipe_ctrl

Interface
REQ-001 Parameter pipe_latency_p, default 4: stages of the fixed-latency FP datapath (legal 2..8).
REQ-002 Parameter reg_addr_width_p, default 5: FP destination register address width.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 dispatch_v_i  input  1  FP instruction offered this cycle.
REQ-006 dispatch_iter_i  input  1  offered op is iterative (div/sqrt); 0 = fixed-latency pipelined op.
REQ-007 dispatch_rd_i  input  reg_addr_width_p  destination register of offered op.
REQ-008 dispatch_ready_o  output  1  controller accepts the offered op; accept = dispatch_v_i & dispatch_ready_o.
REQ-009 flush_i  input  1  squash all in-flight FP work.
REQ-010 pipe_launch_o  output  1  launch strobe to the fixed-latency datapath.
REQ-011 iter_start_o  output  1  start strobe to the iterative unit.
REQ-012 iter_kill_o  output  1  abort strobe to the iterative unit.
REQ-013 iter_done_i  input  1  iterative unit result ready (single-cycle pulse).
REQ-014 wb_v_o  output  1  FP writeback valid.
REQ-015 wb_iter_o  output  1  writeback source: 1 = iterative unit, 0 = pipeline.
REQ-016 wb_rd_o  output  reg_addr_width_p  writeback destination register.
REQ-017 rd_busy_o  output  2**reg_addr_width_p  per-register pending-write scoreboard.
REQ-018 busy_o  output  1  any FP work in flight.

Function
REQ-019 Pipeline tracker: shift register of pipe_latency_p entries {valid, rd}; entry 0 loaded on pipelined accept, all entries advance one per cycle unconditionally.
REQ-020 Pipelined op accepted in cycle N: pipe_launch_o = 1 in cycle N (combinational from accept); wb_v_o = 1, wb_iter_o = 0, wb_rd_o = rd in cycle N+pipe_latency_p.
REQ-021 Iterative FSM states: IDLE, ITER, DONE; reset state IDLE.
REQ-022 IDLE -> ITER on iterative accept; iter_start_o = 1 in the accept cycle; rd captured into iter_rd.
REQ-023 ITER -> DONE on iter_done_i; iter_done_i in IDLE or DONE is ignored.
REQ-024 DONE: wb_v_o = 1, wb_iter_o = 1, wb_rd_o = iter_rd in any cycle where the final pipeline entry is invalid; then DONE -> IDLE next cycle.
REQ-025 Writeback port conflict: the final pipeline entry always wins; DONE holds until a free slot, with no cycle limit.
REQ-026 Scoreboard: rd_busy_o bit r = 1 iff r is the rd of any valid pipeline entry or iter_rd with FSM in ITER/DONE.
REQ-027 dispatch_ready_o = !flush_i & !rd_busy_o[dispatch_rd_i] & (!dispatch_iter_i | FSM == IDLE).
REQ-028 Consequence of REQ-027: no two in-flight ops share an rd; writeback in the same cycle as a dispatch to that rd still stalls the dispatch for that cycle.
REQ-029 Pipelined ops may be accepted while the FSM is ITER/DONE; back-to-back pipelined accepts (one per cycle) are allowed.
REQ-030 flush_i = 1: next cycle all pipeline valids = 0, FSM = IDLE; no dispatch accepted in the flush cycle.
REQ-031 flush_i = 1: iter_kill_o = 1 in the flush cycle if FSM is ITER; wb_v_o is forced to 0 in the flush cycle.
REQ-032 iter_done_i coincident with flush_i: flush wins, FSM -> IDLE, no writeback.
REQ-033 busy_o = any pipeline entry valid | FSM != IDLE.

Reset
REQ-034 reset_i = 1 at a clock edge: all pipeline valids = 0, FSM = IDLE, iter_rd = 0; applies mid-operation with no writeback of in-flight ops.
REQ-035 While reset_i = 1: dispatch_ready_o = 0, and all strobes, wb_v_o, wb_iter_o, busy_o = 0; wb_rd_o = 0; rd_busy_o = 0.
REQ-036 First accept is possible in the cycle after reset_i deasserts.

Verification
REQ-037 Pipelined rd=3 accepted cycle 10 (latency 4) -> pipe_launch_o cycle 10; rd_busy_o[3] = 1 cycles 11-14; wb_v_o, wb_rd_o=3 cycle 14; busy_o = 0 cycle 15.
REQ-038 Pipelined rd=1,2,3,4 accepted cycles 0-3 -> writebacks at cycles 4,5,6,7 in order; dispatch rd=2 at cycle 3 -> dispatch_ready_o = 0.
REQ-039 Iterative rd=7 accepted, iter_done_i in the same cycle the final pipeline entry (rd=5) is valid -> wb rd=5 that cycle; wb_iter_o=1, rd=7 next cycle; second iterative stalled until FSM returns to IDLE.
REQ-040 Flush while in ITER with 2 pipeline ops valid -> iter_kill_o = 1 in the flush cycle; no wb_v_o afterwards; rd_busy_o = 0 and busy_o = 0 next cycle.
REQ-041 reset_i asserted during DONE with wb blocked -> no writeback; all outputs 0 next cycle; late iter_done_i ignored.
REQ-042 Dispatch with dispatch_v_i=1, flush_i=1 -> dispatch_ready_o = 0; no launch; scoreboard unchanged apart from the flush clear.
